// File: rtl/id_ex_multi.sv
// ID->EX pipeline register for a multi-issue core. A bundle with an in-bundle RAW hazard is split:
// the older lanes issue now and the dependent remainder is buffered and issued on later cycles.

module id_ex_multi_chk #(
    parameter int LANES = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             id_valid,
    input logic [LANES-1:0] id_lane_valid
);
    function automatic logic is_prefix(input logic [LANES-1:0] v);
        return ((v + LANES'(1)) & v) == '0;
    endfunction

    // Offered lane valids must form a contiguous run starting at lane 0.
    a_prefix: assert property (@(posedge clk) disable iff (!rst) id_valid |-> is_prefix(id_lane_valid))
        else $error("id_lane_valid is not a contiguous prefix: %b", id_lane_valid);
endmodule

module id_ex_multi #(
    parameter int LANES  = 2,
    parameter int DATA_W = 160,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    id_valid,
    output logic                    id_ready,
    input  logic [LANES-1:0]        id_lane_valid,
    input  logic [LANES*DATA_W-1:0] id_payload,
    input  logic [LANES*PC_W-1:0]   id_pc,
    input  logic [LANES*RA_W-1:0]   id_rs1,
    input  logic [LANES*RA_W-1:0]   id_rs2,
    input  logic [LANES*RA_W-1:0]   id_wd,
    input  logic [LANES-1:0]        id_wreg,
    input  logic                    ex_ready,
    output logic                    ex_valid,
    output logic [LANES-1:0]        ex_lane_valid,
    output logic [LANES*DATA_W-1:0] ex_payload,
    output logic [LANES*PC_W-1:0]   ex_pc,
    output logic [LANES*RA_W-1:0]   ex_wd,
    output logic [LANES-1:0]        ex_wreg,
    output logic                    split_o
);
    localparam int KW = $clog2(LANES + 1);

    typedef enum logic {PASS = 1'b0, SPLIT = 1'b1} state_e;
    state_e state_q, state_d;

    logic [LANES-1:0]        rem_valid_q, rem_valid_d, rem_wreg_q, rem_wreg_d;
    logic [LANES*DATA_W-1:0] rem_payload_q, rem_payload_d;
    logic [LANES*PC_W-1:0]   rem_pc_q, rem_pc_d;
    logic [LANES*RA_W-1:0]   rem_rs1_q, rem_rs1_d, rem_rs2_q, rem_rs2_d, rem_wd_q, rem_wd_d;

    logic [LANES-1:0]        ex_lane_valid_q, ex_lane_valid_d, ex_wreg_q, ex_wreg_d;
    logic [LANES*DATA_W-1:0] ex_payload_q, ex_payload_d;
    logic [LANES*PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic [LANES*RA_W-1:0]   ex_wd_q, ex_wd_d;
    logic                    split_q, split_d;

    logic [LANES-1:0]        cand_valid_s, cand_wreg_s, dep_s;
    logic [LANES*DATA_W-1:0] cand_payload_s;
    logic [LANES*PC_W-1:0]   cand_pc_s;
    logic [LANES*RA_W-1:0]   cand_rs1_s, cand_rs2_s, cand_wd_s;
    logic [KW-1:0]           k_s;
    logic                    advance_s, accept_s, load_s, hazard_s;

    assign advance_s = ~(|ex_lane_valid_q) | ex_ready;
    assign id_ready  = advance_s & (state_q == PASS) & ~flush;
    assign accept_s  = id_valid & id_ready;
    assign load_s    = advance_s & ~flush & ((state_q == SPLIT) | accept_s);

    // Candidate set: the buffered remainder while splitting, otherwise the offered bundle.
    always_comb begin
        if (state_q == SPLIT) begin
            cand_valid_s   = rem_valid_q;
            cand_wreg_s    = rem_wreg_q;
            cand_payload_s = rem_payload_q;
            cand_pc_s      = rem_pc_q;
            cand_rs1_s     = rem_rs1_q;
            cand_rs2_s     = rem_rs2_q;
            cand_wd_s      = rem_wd_q;
        end else begin
            cand_valid_s   = id_lane_valid & {LANES{id_valid}};
            cand_wreg_s    = id_wreg;
            cand_payload_s = id_payload;
            cand_pc_s      = id_pc;
            cand_rs1_s     = id_rs1;
            cand_rs2_s     = id_rs2;
            cand_wd_s      = id_wd;
        end
    end

    // RAW detection against every older valid lane; k_s is the first dependent lane or LANES.
    always_comb begin
        dep_s = '0;
        for (int j = 1; j < LANES; j++) begin
            for (int i = 0; i < j; i++) begin
                dep_s[j] = dep_s[j] | (cand_valid_s[i] & cand_valid_s[j] & cand_wreg_s[i]
                           & (cand_wd_s[i*RA_W +: RA_W] != '0)
                           & ((cand_rs1_s[j*RA_W +: RA_W] == cand_wd_s[i*RA_W +: RA_W])
                            | (cand_rs2_s[j*RA_W +: RA_W] == cand_wd_s[i*RA_W +: RA_W])));
            end
        end
        k_s = KW'(LANES);
        for (int j = LANES - 1; j >= 1; j--) begin
            k_s = dep_s[j] ? KW'(j) : k_s;
        end
        hazard_s = |dep_s;
    end

    // Next state: stay in SPLIT while each load leaves a non-empty remainder.
    always_comb begin
        if (flush) begin
            state_d = PASS;
        end else if (load_s) begin
            state_d = hazard_s ? SPLIT : PASS;
        end else begin
            state_d = state_q;
        end
    end

    // Next register contents for the EX lanes and the compacted remainder buffer.
    always_comb begin
        ex_lane_valid_d = ex_lane_valid_q;
        ex_payload_d    = ex_payload_q;
        ex_pc_d         = ex_pc_q;
        ex_wd_d         = ex_wd_q;
        ex_wreg_d       = ex_wreg_q;
        rem_valid_d     = rem_valid_q;
        rem_wreg_d      = rem_wreg_q;
        rem_payload_d   = rem_payload_q;
        rem_pc_d        = rem_pc_q;
        rem_rs1_d       = rem_rs1_q;
        rem_rs2_d       = rem_rs2_q;
        rem_wd_d        = rem_wd_q;
        split_d         = 1'b0;
        if (flush) begin
            ex_lane_valid_d = '0;
            rem_valid_d     = '0;
        end else if (load_s) begin
            ex_payload_d = cand_payload_s;
            ex_pc_d      = cand_pc_s;
            ex_wd_d      = cand_wd_s;
            ex_wreg_d    = cand_wreg_s;
            for (int i = 0; i < LANES; i++) begin
                ex_lane_valid_d[i] = cand_valid_s[i] & (KW'(i) < k_s);
            end
            for (int m = 0; m < LANES; m++) begin
                if (m + int'(k_s) < LANES) begin
                    rem_valid_d[m] = cand_valid_s[m + int'(k_s)];
                    rem_wreg_d[m]  = cand_wreg_s[m + int'(k_s)];
                    rem_payload_d[m*DATA_W +: DATA_W] = cand_payload_s[(m + int'(k_s))*DATA_W +: DATA_W];
                    rem_pc_d[m*PC_W +: PC_W]          = cand_pc_s[(m + int'(k_s))*PC_W +: PC_W];
                    rem_rs1_d[m*RA_W +: RA_W]         = cand_rs1_s[(m + int'(k_s))*RA_W +: RA_W];
                    rem_rs2_d[m*RA_W +: RA_W]         = cand_rs2_s[(m + int'(k_s))*RA_W +: RA_W];
                    rem_wd_d[m*RA_W +: RA_W]          = cand_wd_s[(m + int'(k_s))*RA_W +: RA_W];
                end else begin
                    rem_valid_d[m] = 1'b0;
                end
            end
            split_d = hazard_s;
        end else if (advance_s) begin
            ex_lane_valid_d = '0;
        end else begin
            ex_lane_valid_d = ex_lane_valid_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // EX-lane and remainder registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_lane_valid_q <= '0;
            ex_payload_q    <= '0;
            ex_pc_q         <= '0;
            ex_wd_q         <= '0;
            ex_wreg_q       <= '0;
            split_q         <= 1'b0;
            rem_valid_q     <= '0;
            rem_wreg_q      <= '0;
            rem_payload_q   <= '0;
            rem_pc_q        <= '0;
            rem_rs1_q       <= '0;
            rem_rs2_q       <= '0;
            rem_wd_q        <= '0;
        end else begin
            ex_lane_valid_q <= ex_lane_valid_d;
            ex_payload_q    <= ex_payload_d;
            ex_pc_q         <= ex_pc_d;
            ex_wd_q         <= ex_wd_d;
            ex_wreg_q       <= ex_wreg_d;
            split_q         <= split_d;
            rem_valid_q     <= rem_valid_d;
            rem_wreg_q      <= rem_wreg_d;
            rem_payload_q   <= rem_payload_d;
            rem_pc_q        <= rem_pc_d;
            rem_rs1_q       <= rem_rs1_d;
            rem_rs2_q       <= rem_rs2_d;
            rem_wd_q        <= rem_wd_d;
        end
    end

    assign ex_lane_valid = ex_lane_valid_q;
    assign ex_valid      = |ex_lane_valid_q;
    assign ex_payload    = ex_payload_q;
    assign ex_pc         = ex_pc_q;
    assign ex_wd         = ex_wd_q;
    assign ex_wreg       = ex_wreg_q;
    assign split_o       = split_q;

    id_ex_multi_chk #(.LANES(LANES)) u_chk (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_lane_valid (id_lane_valid)
    );
endmodule

// File: tb/tb_id_ex_multi.sv
// Bench for id_ex_multi (4 lanes): directed scenarios followed by randomized traffic, all checked
// against an instruction-queue reference model.

module tb_id_ex_multi;
    localparam int L = 4, DW = 32, PW = 32, RW = 5;

    logic clk = 1'b0;
    logic rst, flush, id_valid, ex_ready, id_ready, ex_valid, split_o;
    logic [L-1:0]    id_lane_valid, id_wreg, ex_lane_valid, ex_wreg;
    logic [L*DW-1:0] id_payload, ex_payload;
    logic [L*PW-1:0] id_pc, ex_pc;
    logic [L*RW-1:0] id_rs1, id_rs2, id_wd, ex_wd;

    id_ex_multi #(.LANES(L), .DATA_W(DW), .PC_W(PW), .RA_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_lane_valid(id_lane_valid), .id_payload(id_payload), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_wd(id_wd), .id_wreg(id_wreg),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_lane_valid(ex_lane_valid),
        .ex_payload(ex_payload), .ex_pc(ex_pc), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .split_o(split_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pl;
        logic [PW-1:0] pc;
        logic [RW-1:0] rs1, rs2, wd;
        logic          wreg;
    } ins_t;

    // Reference model: instructions now in EX, instructions still waiting from a split bundle.
    ins_t m_ex[L];
    int   m_n;
    ins_t m_rem[$];
    logic m_split;
    int   checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t in_lane(input int i);
        ins_t r;
        r.pl = id_payload[i*DW +: DW]; r.pc = id_pc[i*PW +: PW];
        r.rs1 = id_rs1[i*RW +: RW]; r.rs2 = id_rs2[i*RW +: RW];
        r.wd = id_wd[i*RW +: RW]; r.wreg = id_wreg[i];
        return r;
    endfunction

    // Number of leading instructions that can issue together: stop at the first reader of an older result.
    function automatic int issue_len(input ins_t c[$]);
        for (int j = 0; j < c.size(); j++)
            for (int i = 0; i < j; i++)
                if (c[i].wreg && c[i].wd != 0 && (c[j].rs1 == c[i].wd || c[j].rs2 == c[i].wd))
                    return j;
        return c.size();
    endfunction

    task automatic set_lane(input int i, input logic [PW-1:0] pc, input logic [RW-1:0] rs1,
                            input logic [RW-1:0] rs2, input logic [RW-1:0] wd, input logic wreg);
        id_payload[i*DW +: DW] = $urandom;
        id_pc[i*PW +: PW] = pc; id_rs1[i*RW +: RW] = rs1; id_rs2[i*RW +: RW] = rs2;
        id_wd[i*RW +: RW] = wd; id_wreg[i] = wreg;
    endtask

    task automatic clr();
        id_valid = 1'b0; id_lane_valid = '0; id_payload = '0; id_pc = '0;
        id_rs1 = '0; id_rs2 = '0; id_wd = '0; id_wreg = '0;
    endtask

    task automatic model_reset();
        m_n = 0; m_rem.delete(); m_split = 1'b0;
    endtask

    task automatic compare();
        chk("ex_lane_valid", 64'(ex_lane_valid), 64'((1 << m_n) - 1));
        chk("ex_valid", 64'(ex_valid), 64'(m_n != 0));
        chk("split_o", 64'(split_o), 64'(m_split));
        for (int i = 0; i < m_n; i++) begin
            chk($sformatf("payload%0d", i), 64'(ex_payload[i*DW +: DW]), 64'(m_ex[i].pl));
            chk($sformatf("pc%0d", i), 64'(ex_pc[i*PW +: PW]), 64'(m_ex[i].pc));
            chk($sformatf("wd%0d", i), 64'(ex_wd[i*RW +: RW]), 64'(m_ex[i].wd));
            chk($sformatf("wreg%0d", i), 64'(ex_wreg[i]), 64'(m_ex[i].wreg));
        end
    endtask

    // One clock: inputs are already driven; check id_ready mid-cycle, predict, clock, compare.
    task automatic step();
        ins_t cand[$];
        int   c;
        logic adv;
        #4;
        adv = (m_n == 0) || ex_ready;
        chk("id_ready", 64'(id_ready), 64'(adv && m_rem.size() == 0 && !flush));
        if (flush) begin
            model_reset();
        end else if (!adv) begin
            m_split = 1'b0;
        end else begin
            if (m_rem.size() > 0) cand = m_rem;
            else if (id_valid)
                for (int i = 0; i < L; i++) if (id_lane_valid[i]) cand.push_back(in_lane(i));
            c = issue_len(cand);
            m_n = c;
            for (int i = 0; i < c; i++) m_ex[i] = cand[i];
            m_rem.delete();
            for (int i = c; i < cand.size(); i++) m_rem.push_back(cand[i]);
            m_split = (m_rem.size() > 0);
        end
        @(posedge clk); #1;
        compare();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lv"}, 64'(ex_lane_valid), 64'd0);
        chk({tag, "_valid"}, 64'(ex_valid), 64'd0);
        chk({tag, "_split"}, 64'(split_o), 64'd0);
        chk({tag, "_wreg"}, 64'(ex_wreg), 64'd0);
        chk({tag, "_wd"}, 64'(ex_wd), 64'd0);
        for (int i = 0; i < L; i++) begin
            chk({tag, "_payload"}, 64'(ex_payload[i*DW +: DW]), 64'd0);
            chk({tag, "_pc"}, 64'(ex_pc[i*PW +: PW]), 64'd0);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1; clr(); model_reset();
        @(posedge clk); #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // Independent pair issues together.
        set_lane(0, 32'h40, 5'd1, 5'd2, 5'd3, 1'b1); set_lane(1, 32'h44, 5'd4, 5'd0, 5'd6, 1'b1);
        id_valid = 1'b1; id_lane_valid = 4'b0011;
        step();
        chk("t2_lv", 64'(ex_lane_valid), 64'h3); chk("t2_split", 64'(split_o), 64'd0);

        // RAW on rs2 splits the pair.
        set_lane(0, 32'h100, 5'd0, 5'd0, 5'd5, 1'b1); set_lane(1, 32'h104, 5'd0, 5'd5, 5'd7, 1'b1);
        step();
        chk("t3_lv1", 64'(ex_lane_valid), 64'h1); chk("t3_split", 64'(split_o), 64'd1);
        chk("t3_pc0", 64'(ex_pc[PW-1:0]), 64'h100);
        clr();
        step();
        chk("t3_lv2", 64'(ex_lane_valid), 64'h1); chk("t3_pc1", 64'(ex_pc[PW-1:0]), 64'h104);
        chk("t3_ready", 64'(id_ready), 64'd1);

        // Writes to x0 and non-writing lanes never split.
        set_lane(0, 32'h200, 5'd0, 5'd0, 5'd0, 1'b1); set_lane(1, 32'h204, 5'd0, 5'd2, 5'd1, 1'b1);
        id_valid = 1'b1; id_lane_valid = 4'b0011;
        step();
        chk("t4a_lv", 64'(ex_lane_valid), 64'h3);
        set_lane(0, 32'h300, 5'd1, 5'd1, 5'd5, 1'b0); set_lane(1, 32'h304, 5'd5, 5'd1, 5'd2, 1'b1);
        step();
        chk("t4b_lv", 64'(ex_lane_valid), 64'h3);

        // Stall for three cycles with a new bundle waiting, then release.
        set_lane(0, 32'h400, 5'd1, 5'd2, 5'd3, 1'b1); set_lane(1, 32'h404, 5'd6, 5'd7, 5'd8, 1'b1);
        set_lane(2, 32'h408, 5'd9, 5'd10, 5'd11, 1'b1);
        id_lane_valid = 4'b0111; ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ex_ready = 1'b1;
        step();
        chk("t5_pc2", 64'(ex_pc[2*PW +: PW]), 64'h408);

        // Flush with a remainder pending: the remainder never issues.
        set_lane(0, 32'h500, 5'd0, 5'd0, 5'd4, 1'b1); set_lane(1, 32'h504, 5'd4, 5'd0, 5'd2, 1'b1);
        id_lane_valid = 4'b0011;
        step();
        clr(); flush = 1'b1;
        step();
        chk("t6_lv", 64'(ex_lane_valid), 64'h0);
        flush = 1'b0;
        step(); step();
        chk("t6_gone", 64'(ex_lane_valid), 64'h0);

        // Four-lane chain issues as 0001, 0011, 0001.
        set_lane(0, 32'h600, 5'd0, 5'd0, 5'd1, 1'b1); set_lane(1, 32'h604, 5'd1, 5'd0, 5'd2, 1'b1);
        set_lane(2, 32'h608, 5'd0, 5'd0, 5'd3, 1'b1); set_lane(3, 32'h60c, 5'd0, 5'd3, 5'd4, 1'b1);
        id_valid = 1'b1; id_lane_valid = 4'b1111;
        step(); chk("chain1", 64'(ex_lane_valid), 64'h1);
        clr();
        step(); chk("chain2", 64'(ex_lane_valid), 64'h3);
        step(); chk("chain3", 64'(ex_lane_valid), 64'h1);

        // Asynchronous reset while a split is pending.
        set_lane(0, 32'h700, 5'd0, 5'd0, 5'd1, 1'b1); set_lane(1, 32'h704, 5'd1, 5'd0, 5'd2, 1'b1);
        id_valid = 1'b1; id_lane_valid = 4'b0011;
        step();
        clr(); rst = 1'b0; #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("midrst_ready", 64'(id_ready), 64'd1);
        step();

        // Randomized traffic with a small register space to provoke hazards.
        for (int t = 0; t < 400; t++) begin
            ex_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            n = $urandom_range(1, L);
            id_lane_valid = L'((1 << n) - 1);
            for (int i = 0; i < L; i++)
                set_lane(i, PW'($urandom), RW'($urandom_range(0, 4)), RW'($urandom_range(0, 4)),
                         RW'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
